sel_encode_sb: RTL and testbench

Parametrised select-and-encode unit with a latched instruction register and a per-register busy scoreboard. It sits between the IR and the general-purpose register file of the datapath. It decodes the Ra/Rb/Rc fields into one-hot register-file enables and sign-extends the C constant. It also tracks in-flight destination registers so that the control unit can stall issue on read-after-write and write-after-write hazards.

---
 rtl/sel_encode_sb.sv | 113 +++++++++++
 tb/tb_sel_encode_sb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sel_encode_sb.sv
// Select-and-encode unit: latched IR, Ra/Rb/Rc one-hot register enables,
// C sign-extension and a per-register busy scoreboard for RAW/WAW issue stalls.
module sel_encode_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15,
  parameter int C_W    = 19,
  localparam int REG_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] IR_in,
  input  logic              IR_load,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  output logic [NREGS-1:0]  GenReg_In,
  output logic [NREGS-1:0]  GenReg_Out,
  output logic              BA_zero,
  output logic [DATA_W-1:0] C_sign_extended,
  input  logic              issue_valid,
  input  logic              use_ra_dst,
  input  logic              use_rb_src,
  input  logic              use_rc_src,
  output logic              issue_ready,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_reg,
  output logic [NREGS-1:0]  busy,
  output logic [REG_W:0]    busy_count
);

  function automatic logic [NREGS-1:0] onehot(input logic [REG_W-1:0] idx);
    logic [NREGS-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [REG_W:0] popcount(input logic [NREGS-1:0] v);
    logic [REG_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) cnt = cnt + (REG_W+1)'(v[i]);
    return cnt;
  endfunction

  function automatic logic signed [DATA_W-1:0] sext_c(input logic [DATA_W-1:0] ir);
    logic signed [C_W-1:0] c;
    c = $signed(ir[C_W-1:0]);
    return DATA_W'(c);
  endfunction

  logic [DATA_W-1:0] ir_p0;
  logic [REG_W-1:0]  ra, rb, rc, sel;
  logic              sel_valid;
  logic [NREGS-1:0]  sel_1h, wb_1h, eff_busy, set_1h, busy_nxt;
  logic              hazard, accept;
  logic              unused_ir;

  assign ra = ir_p0[RA_LSB +: REG_W];
  assign rb = ir_p0[RB_LSB +: REG_W];
  assign rc = ir_p0[RC_LSB +: REG_W];
  // Bits of the IR outside the decoded fields are intentionally ignored.
  assign unused_ir = ^ir_p0;

  always_comb begin
    sel       = '0;
    sel_valid = 1'b1;
    if (Gra)      sel = ra;
    else if (Grb) sel = rb;
    else if (Grc) sel = rc;
    else          sel_valid = 1'b0;
  end

  assign sel_1h          = sel_valid ? onehot(sel) : '0;
  assign BA_zero         = BAout && sel_valid && (sel == '0);
  assign GenReg_In       = Rin ? sel_1h : '0;
  assign GenReg_Out      = ((Rout || BAout) && !BA_zero) ? sel_1h : '0;
  assign C_sign_extended = sext_c(ir_p0);

  // Same-cycle writeback bypass: a register being written back no longer blocks issue.
  assign wb_1h    = wb_valid ? onehot(wb_reg) : '0;
  assign eff_busy = busy & ~wb_1h;
  assign hazard   = (use_rb_src && eff_busy[rb]) ||
                    (use_rc_src && eff_busy[rc]) ||
                    (use_ra_dst && eff_busy[ra]);
  assign issue_ready = !hazard;
  assign stall       = issue_valid && hazard;
  assign accept      = issue_valid && !hazard;

  // Set is applied after the clear so an issue to the written-back register wins.
  assign set_1h   = (accept && use_ra_dst) ? onehot(ra) : '0;
  assign busy_nxt = eff_busy | set_1h;

  // ---- stage p0: IR and scoreboard registers ----
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ir_p0      <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (IR_load) ir_p0 <= IR_in;
      busy       <= busy_nxt;
      busy_count <= popcount(busy_nxt);
    end
  end

endmodule

// File: tb/tb_sel_encode_sb.sv
// Directed bench for sel_encode_sb: table of decode vectors plus hand-written
// scoreboard sequences (RAW stall, collision, fill, mid-cycle clear).
module tb_sel_encode_sb;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR_in = '0;
  logic        IR_load = 1'b0;
  logic        Gra = 0, Grb = 0, Grc = 0, Rin = 0, Rout = 0, BAout = 0;
  logic [15:0] GenReg_In, GenReg_Out;
  logic        BA_zero;
  logic [31:0] C_sign_extended;
  logic        issue_valid = 0, use_ra_dst = 0, use_rb_src = 0, use_rc_src = 0;
  logic        issue_ready, stall;
  logic        wb_valid = 0;
  logic [3:0]  wb_reg = '0;
  logic [15:0] busy;
  logic [4:0]  busy_count;

  int n_total = 0;
  int n_pass  = 0;

  sel_encode_sb dut (
    .clock(clock), .clear(clear), .IR_in(IR_in), .IR_load(IR_load),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .GenReg_In(GenReg_In), .GenReg_Out(GenReg_Out), .BA_zero(BA_zero),
    .C_sign_extended(C_sign_extended),
    .issue_valid(issue_valid), .use_ra_dst(use_ra_dst), .use_rb_src(use_rb_src),
    .use_rc_src(use_rc_src), .issue_ready(issue_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .busy(busy), .busy_count(busy_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ir;
    logic [5:0]  ctl;      // {Gra, Grb, Grc, Rin, Rout, BAout}
    logic [15:0] exp_in;
    logic [15:0] exp_out;
    logic        exp_ba;
    logic [31:0] exp_c;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] v);
    IR_in = v;
    IR_load = 1'b1;
    tick();
    IR_load = 1'b0;
    IR_in = 32'hDEAD_BEEF;
  endtask

  function automatic logic [31:0] mk_ir(input int ra, input int rb, input int rc);
    return (32'(ra) << 23) | (32'(rb) << 19) | (32'(rc) << 15);
  endfunction

  task automatic issue_dst(input int ra);
    set_ir(mk_ir(ra, 0, 0));
    issue_valid = 1; use_ra_dst = 1;
    tick();
    issue_valid = 0; use_ra_dst = 0;
  endtask

  initial begin
    vecs[0]  = '{32'h01A8_0000, 6'b100100, 16'h0008, 16'h0000, 1'b0, 32'h0000_0000};
    vecs[1]  = '{32'h01A8_0000, 6'b010010, 16'h0000, 16'h0020, 1'b0, 32'h0000_0000};
    vecs[2]  = '{32'h01A8_0000, 6'b001110, 16'h0001, 16'h0001, 1'b0, 32'h0000_0000};
    vecs[3]  = '{32'h01A8_0000, 6'b001001, 16'h0000, 16'h0000, 1'b1, 32'h0000_0000};
    vecs[4]  = '{32'h01A8_0000, 6'b000110, 16'h0000, 16'h0000, 1'b0, 32'h0000_0000};
    vecs[5]  = '{32'h0004_0000, 6'b100100, 16'h0001, 16'h0000, 1'b0, 32'hFFFC_0000};
    vecs[6]  = '{32'h0004_0000, 6'b001010, 16'h0000, 16'h0100, 1'b0, 32'hFFFC_0000};
    vecs[7]  = '{32'h0038_0000, 6'b110001, 16'h0000, 16'h0000, 1'b1, 32'h0000_0000};
    vecs[8]  = '{32'h0038_0000, 6'b010001, 16'h0000, 16'h0080, 1'b0, 32'h0000_0000};
    vecs[9]  = '{32'h0038_0000, 6'b010011, 16'h0000, 16'h0080, 1'b0, 32'h0000_0000};
    vecs[10] = '{32'h0038_0000, 6'b100010, 16'h0000, 16'h0001, 1'b0, 32'h0000_0000};
    vecs[11] = '{32'h0003_FFFF, 6'b001100, 16'h0080, 16'h0000, 1'b0, 32'h0003_FFFF};
    vecs[12] = '{32'h0007_FFFF, 6'b001010, 16'h0000, 16'h8000, 1'b0, 32'hFFFF_FFFF};
    vecs[13] = '{32'h01A8_0000, 6'b111100, 16'h0008, 16'h0000, 1'b0, 32'h0000_0000};

    // Reset state
    tick(); tick();
    clear = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_count", 64'(busy_count), 64'h0);
    chk("rst_c", 64'(C_sign_extended), 64'h0);
    chk("rst_ready", 64'(issue_ready), 64'h1);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_ba", 64'(BA_zero), 64'h0);
    chk("rst_in", 64'(GenReg_In), 64'h0);
    chk("rst_out", 64'(GenReg_Out), 64'h0);

    // Table-driven decode vectors
    for (int i = 0; i < 14; i++) begin
      set_ir(vecs[i].ir);
      {Gra, Grb, Grc, Rin, Rout, BAout} = vecs[i].ctl;
      #1;
      chk($sformatf("v%0d_in", i), 64'(GenReg_In), 64'(vecs[i].exp_in));
      chk($sformatf("v%0d_out", i), 64'(GenReg_Out), 64'(vecs[i].exp_out));
      chk($sformatf("v%0d_ba", i), 64'(BA_zero), 64'(vecs[i].exp_ba));
      chk($sformatf("v%0d_c", i), 64'(C_sign_extended), 64'(vecs[i].exp_c));
      {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    end

    // IR holds without IR_load
    IR_in = 32'h0007_FFFF;
    tick();
    chk("ir_hold", 64'(C_sign_extended), 64'h0000_0000);

    // RAW stall and same-cycle writeback bypass
    issue_dst(4);
    chk("raw_busy", 64'(busy), 64'h0010);
    chk("raw_count", 64'(busy_count), 64'h1);
    set_ir(mk_ir(1, 4, 0));
    issue_valid = 1; use_rb_src = 1; use_ra_dst = 1;
    #1;
    chk("raw_stall", 64'(stall), 64'h1);
    chk("raw_notready", 64'(issue_ready), 64'h0);
    tick();
    chk("raw_held", 64'(busy), 64'h0010);
    wb_valid = 1; wb_reg = 4'd4;
    #1;
    chk("bypass_ready", 64'(issue_ready), 64'h1);
    chk("bypass_stall", 64'(stall), 64'h0);
    tick();
    issue_valid = 0; use_rb_src = 0; use_ra_dst = 0; wb_valid = 0;
    chk("bypass_busy", 64'(busy), 64'h0002);
    chk("bypass_count", 64'(busy_count), 64'h1);

    // Writeback of r1, then set/clear collision on r6
    wb_valid = 1; wb_reg = 4'd1;
    tick();
    wb_valid = 0;
    chk("wb_clear", 64'(busy), 64'h0);
    issue_dst(6);
    chk("col_pre", 64'(busy), 64'h0040);
    issue_valid = 1; use_ra_dst = 1; wb_valid = 1; wb_reg = 4'd6;
    #1;
    chk("col_ready", 64'(issue_ready), 64'h1);
    tick();
    issue_valid = 0; use_ra_dst = 0;
    chk("col_busy", 64'(busy), 64'h0040);
    chk("col_count", 64'(busy_count), 64'h1);
    wb_reg = 4'd9;
    tick();
    chk("wb_notbusy", 64'(busy), 64'h0040);
    wb_reg = 4'd6;
    tick();
    wb_valid = 0;
    chk("wb6_clear", 64'(busy_count), 64'h0);

    // IR_load concurrent with issue: issue uses the old IR (Ra=10)
    set_ir(mk_ir(10, 0, 0));
    IR_in = mk_ir(11, 0, 0); IR_load = 1; issue_valid = 1; use_ra_dst = 1;
    tick();
    IR_load = 0; issue_valid = 0; use_ra_dst = 0;
    chk("ldiss_busy", 64'(busy), 64'h0400);
    Gra = 1; Rin = 1;
    #1;
    chk("ldiss_newir", 64'(GenReg_In), 64'h0800);
    Gra = 0; Rin = 0;
    wb_valid = 1; wb_reg = 4'd10;
    tick();
    wb_valid = 0;

    // Fill every destination
    for (int r = 0; r < 16; r++) issue_dst(r);
    chk("fill_busy", 64'(busy), 64'hFFFF);
    chk("fill_count", 64'(busy_count), 64'd16);
    set_ir(mk_ir(3, 0, 2));
    issue_valid = 1; use_ra_dst = 1;
    #1;
    chk("fill_waw_stall", 64'(stall), 64'h1);
    use_ra_dst = 0; use_rc_src = 1;
    #1;
    chk("fill_rc_stall", 64'(stall), 64'h1);
    use_rc_src = 0;
    #1;
    chk("fill_nouse_ready", 64'(issue_ready), 64'h1);
    tick();
    issue_valid = 0;
    chk("fill_keep", 64'(busy), 64'hFFFF);

    // Mid-cycle asynchronous clear with busy=0x00F0
    clear = 1'b1; tick(); clear = 1'b0;
    for (int r = 4; r < 8; r++) issue_dst(r);
    chk("pre_clr_busy", 64'(busy), 64'h00F0);
    chk("pre_clr_count", 64'(busy_count), 64'd4);
    set_ir(mk_ir(7, 0, 0));
    Gra = 1; Rin = 1; issue_valid = 1; use_ra_dst = 1;
    #1;
    chk("pre_clr_stall", 64'(stall), 64'h1);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_busy", 64'(busy), 64'h0);
    chk("clr_count", 64'(busy_count), 64'h0);
    chk("clr_ir", 64'(GenReg_In), 64'h0001);
    chk("clr_ready", 64'(issue_ready), 64'h1);
    issue_valid = 0; use_ra_dst = 0; Gra = 0; Rin = 0;
    tick();
    clear = 1'b0;
    tick();
    chk("post_clr_busy", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
